ct_biu_no_op_resp: RTL and testbench



---
 rtl/ct_biu_no_op_resp_if.sv | 28 ++
 rtl/ct_biu_no_op_resp.sv | 130 +++++++++++++
 tb/tb_ct_biu_no_op_resp.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ct_biu_no_op_resp_if.sv
// Issue/completion handshake between the request arbiters, the AXI side and the no-op responder.
// master = upstream/AXI side driving requests and completions; slave = responder returning grants.
interface ct_biu_no_op_resp_if;
    logic rd_req_vld;
    logic rd_req_grnt;
    logic wr_req_vld;
    logic wr_req_grnt;
    logic rd_cmplt;
    logic wr_cmplt;

    modport master (
        output rd_req_vld,
        output wr_req_vld,
        output rd_cmplt,
        output wr_cmplt,
        input  rd_req_grnt,
        input  wr_req_grnt
    );

    modport slave (
        input  rd_req_vld,
        input  wr_req_vld,
        input  rd_cmplt,
        input  wr_cmplt,
        output rd_req_grnt,
        output wr_req_grnt
    );
endinterface

// File: rtl/ct_biu_no_op_resp.sv
// CP0 low-power responder: blocks issue, drains, acks no_op one cycle after drain, mirrors lpmd code.
// Grants drop whenever not RUN or at max outstanding; BIU_LPMD_RESIDENCY_CNT_EN adds residency counters.
module ct_biu_no_op_resp #(
    parameter int RD_MAX = 8,
    parameter int WR_MAX = 8,
    parameter int CNT_W  = 4
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 cp0_biu_no_op_req,
    input  logic [1:0]           cp0_biu_lpmd_b,
    ct_biu_no_op_resp_if.slave   bus,
    output logic                 biu_yy_xx_no_op,
    output logic [1:0]           biu_pad_lpmd_b,
    output logic                 biu_cnt_err,
`ifdef BIU_LPMD_RESIDENCY_CNT_EN
    output logic [31:0]          biu_lpmd_cycles,
    output logic [15:0]          biu_lpmd_entries,
`endif
    output logic [1:0]           biu_lpmd_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_BLOCK = 2'b01,
        ST_NOOP  = 2'b10,
        ST_LPMD  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(RD_MAX);
    localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(WR_MAX);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt_nxt;
    logic [CNT_W-1:0] wr_cnt_nxt;
    logic             rd_undf;
    logic             wr_undf;
    logic             rd_issue;
    logic             wr_issue;
    logic             lpmd_run;

    assign lpmd_run = (cp0_biu_lpmd_b == 2'b11);

    // Grants look only at registered state so there is no vld->grnt timing path.
    assign bus.rd_req_grnt = (state == ST_RUN) && (rd_cnt < RD_LIM);
    assign bus.wr_req_grnt = (state == ST_RUN) && (wr_cnt < WR_LIM);
    assign rd_issue        = bus.rd_req_vld && bus.rd_req_grnt;
    assign wr_issue        = bus.wr_req_vld && bus.wr_req_grnt;

    assign biu_yy_xx_no_op = (state == ST_NOOP);
    assign biu_lpmd_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (cp0_biu_no_op_req) state_nxt = ST_BLOCK;
            end
            ST_BLOCK: begin
                if (!cp0_biu_no_op_req)                   state_nxt = ST_RUN;
                else if (rd_cnt == '0 && wr_cnt == '0)    state_nxt = ST_NOOP;
            end
            ST_NOOP: begin
                if (!lpmd_run)               state_nxt = ST_LPMD;
                else if (!cp0_biu_no_op_req) state_nxt = ST_RUN;
            end
            ST_LPMD: begin
                if (lpmd_run) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // A completion against an empty counter is a protocol error; the counter stays at zero.
    always_comb begin
        rd_cnt_nxt = rd_cnt;
        rd_undf    = 1'b0;
        if (rd_issue && !bus.rd_cmplt) begin
            rd_cnt_nxt = rd_cnt + 1'b1;
        end else if (!rd_issue && bus.rd_cmplt) begin
            if (rd_cnt == '0) rd_undf    = 1'b1;
            else              rd_cnt_nxt = rd_cnt - 1'b1;
        end
    end

    always_comb begin
        wr_cnt_nxt = wr_cnt;
        wr_undf    = 1'b0;
        if (wr_issue && !bus.wr_cmplt) begin
            wr_cnt_nxt = wr_cnt + 1'b1;
        end else if (!wr_issue && bus.wr_cmplt) begin
            if (wr_cnt == '0) wr_undf    = 1'b1;
            else              wr_cnt_nxt = wr_cnt - 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state          <= ST_RUN;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            biu_pad_lpmd_b <= 2'b11;
            biu_cnt_err    <= 1'b0;
        end else begin
            state          <= state_nxt;
            rd_cnt         <= rd_cnt_nxt;
            wr_cnt         <= wr_cnt_nxt;
            biu_pad_lpmd_b <= cp0_biu_lpmd_b;
            if (rd_undf || wr_undf) biu_cnt_err <= 1'b1;
        end
    end

`ifdef BIU_LPMD_RESIDENCY_CNT_EN
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            biu_lpmd_cycles  <= '0;
            biu_lpmd_entries <= '0;
        end else begin
            if (state == ST_LPMD && biu_lpmd_cycles != 32'hFFFF_FFFF)
                biu_lpmd_cycles <= biu_lpmd_cycles + 32'd1;
            if (state == ST_NOOP && state_nxt == ST_LPMD)
                biu_lpmd_entries <= biu_lpmd_entries + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ct_biu_no_op_resp.sv
// Scoreboard bench for ct_biu_no_op_resp: expectations queued with stimulus, checked after each edge.
module tb_ct_biu_no_op_resp;

    localparam logic [1:0] RUN = 2'b00, BLK = 2'b01, NOP = 2'b10, LPM = 2'b11;
    localparam int S_STATE = 0, S_NOOP = 1, S_RGNT = 2, S_WGNT = 3, S_PAD = 4,
                   S_ERR = 5, S_CYC = 6, S_ENT = 7, S_RCNT = 8, S_WCNT = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  lpmd;
    logic        no_op;
    logic [1:0]  pad;
    logic        err;
    logic [1:0]  st;
`ifdef BIU_LPMD_RESIDENCY_CNT_EN
    logic [31:0] cyc;
    logic [15:0] ent;
`endif

    always #5 clk = ~clk;

    ct_biu_no_op_resp_if bus();

    ct_biu_no_op_resp dut (
        .forever_cpuclk    (clk),
        .cpurst            (rst),
        .cp0_biu_no_op_req (req),
        .cp0_biu_lpmd_b    (lpmd),
        .bus               (bus),
        .biu_yy_xx_no_op   (no_op),
        .biu_pad_lpmd_b    (pad),
        .biu_cnt_err       (err),
`ifdef BIU_LPMD_RESIDENCY_CNT_EN
        .biu_lpmd_cycles   (cyc),
        .biu_lpmd_entries  (ent),
`endif
        .biu_lpmd_state    (st)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] want;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wcnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATE: return 32'(st);
            S_NOOP:  return 32'(no_op);
            S_RGNT:  return 32'(bus.rd_req_grnt);
            S_WGNT:  return 32'(bus.wr_req_grnt);
            S_PAD:   return 32'(pad);
            S_ERR:   return 32'(err);
`ifdef BIU_LPMD_RESIDENCY_CNT_EN
            S_CYC:   return cyc;
            S_ENT:   return 32'(ent);
`endif
            S_RCNT:  return 32'(dut.rd_cnt);
            S_WCNT:  return 32'(dut.wr_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] want);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.want = want;
        sb.push_back(e);
    endtask

    // state, no_op and both grants (grants equal) in one go
    task automatic push_ctl(input string tag, input logic [1:0] s, input logic n, input logic g);
        push({tag, ".state"}, S_STATE, 32'(s));
        push({tag, ".no_op"}, S_NOOP,  32'(n));
        push({tag, ".rgnt"},  S_RGNT,  32'(g));
        push({tag, ".wgnt"},  S_WGNT,  32'(g));
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; lpmd = 2'b11;
        bus.rd_req_vld = 1'b0; bus.wr_req_vld = 1'b0;
        bus.rd_cmplt = 1'b0; bus.wr_cmplt = 1'b0;

        // reset state
        push_ctl("rst", RUN, 1'b0, 1'b1);
        push("rst.pad", S_PAD, 32'h3);
        push("rst.err", S_ERR, 32'h0);
        push("rst.rcnt", S_RCNT, 32'h0);
        push("rst.wcnt", S_WCNT, 32'h0);
`ifdef BIU_LPMD_RESIDENCY_CNT_EN
        push("rst.cyc", S_CYC, 32'h0);
        push("rst.ent", S_ENT, 32'h0);
`endif
        step();
        step();
        rst = 1'b0;

        // idle quiesce: BLOCK after 1 edge, no_op after 2
        req = 1'b1;
        push_ctl("idle.c0", RUN, 1'b0, 1'b1);
        drain();
        push_ctl("idle.c1", BLK, 1'b0, 1'b0);
        step();
        push_ctl("idle.c2", NOP, 1'b1, 1'b0);
        step();
        req = 1'b0;
        push_ctl("idle.exit", RUN, 1'b0, 1'b1);
        step();

        // drain: the issue in the request-rise cycle still counts
        bus.rd_req_vld = 1'b1; bus.wr_req_vld = 1'b1;
        step();
        step();
        bus.wr_req_vld = 1'b0;
        push("drn.rcnt3", S_RCNT, 32'd3);
        push("drn.wcnt2", S_WCNT, 32'd2);
        step();
        req = 1'b1; bus.wr_req_vld = 1'b1;
        push_ctl("drn.blk", BLK, 1'b0, 1'b0);
        push("drn.rcnt4", S_RCNT, 32'd4);
        push("drn.wcnt3", S_WCNT, 32'd3);
        step();
        for (int i = 0; i < 7; i++) begin
            bus.rd_cmplt = (i < 4);
            bus.wr_cmplt = (i >= 4);
            push_ctl($sformatf("drn.cmp%0d", i), BLK, 1'b0, 1'b0);
            push($sformatf("drn.cmp%0d.rcnt", i), S_RCNT, (i < 4) ? 32'(3 - i) : 32'd0);
            push($sformatf("drn.cmp%0d.wcnt", i), S_WCNT, (i < 4) ? 32'd3 : 32'(6 - i));
            step();
        end
        bus.rd_cmplt = 1'b0; bus.wr_cmplt = 1'b0;
        bus.rd_req_vld = 1'b0; bus.wr_req_vld = 1'b0;
        push_ctl("drn.noop", NOP, 1'b1, 1'b0);
        step();
        push_ctl("drn.hold", NOP, 1'b1, 1'b0);
        step();

        // LPMD round trip: lpmd code wins over dropped request
        req = 1'b0; lpmd = 2'b00;
        push_ctl("lp.enter", LPM, 1'b0, 1'b0);
        push("lp.pad00", S_PAD, 32'h0);
        step();
        push_ctl("lp.hold", LPM, 1'b0, 1'b0);
        step();
        lpmd = 2'b11;
        push_ctl("lp.wake", RUN, 1'b0, 1'b1);
        push("lp.pad11", S_PAD, 32'h3);
        step();

        // abort from BLOCK with reads outstanding
        bus.rd_req_vld = 1'b1;
        step();
        step();
        bus.rd_req_vld = 1'b0; req = 1'b1;
        push("ab.blk", S_STATE, 32'(BLK));
        push("ab.rcnt", S_RCNT, 32'd2);
        step();
        req = 1'b0;
        push_ctl("ab.run", RUN, 1'b0, 1'b1);
        push("ab.rcnt2", S_RCNT, 32'd2);
        step();
        push("ab.nonoop", S_NOOP, 32'd0);
        step();
        bus.rd_cmplt = 1'b1;
        step();
        push("ab.rcnt0", S_RCNT, 32'd0);
        step();
        bus.rd_cmplt = 1'b0;

        // read limit, simultaneous issue+completion
        bus.rd_req_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push($sformatf("max.rcnt%0d", i + 1), S_RCNT, 32'(i + 1));
            push($sformatf("max.rgnt%0d", i + 1), S_RGNT, 32'(i + 1 < 8));
            step();
        end
        push("max.sat", S_RCNT, 32'd8);
        push("max.gnt0", S_RGNT, 32'd0);
        step();
        bus.rd_cmplt = 1'b1;
        push("max.dec", S_RCNT, 32'd7);
        push("max.gnt1", S_RGNT, 32'd1);
        step();
        push("sim.rcnt7", S_RCNT, 32'd7);
        push("sim.err", S_ERR, 32'd0);
        step();
        bus.rd_req_vld = 1'b0;
        for (int i = 0; i < 7; i++) step();
        push("max.empty", S_RCNT, 32'd0);
        drain();

        // issue+completion at zero is not an error; bare completion is
        bus.rd_req_vld = 1'b1;
        push("z.sim.rcnt", S_RCNT, 32'd0);
        push("z.sim.err", S_ERR, 32'd0);
        step();
        bus.rd_req_vld = 1'b0;
        push("z.err", S_ERR, 32'd1);
        push("z.rcnt", S_RCNT, 32'd0);
        step();
        bus.rd_cmplt = 1'b0;
        push("z.sticky", S_ERR, 32'd1);
        step();

        // random write traffic against a simple outstanding count
        for (int i = 0; i < 150; i++) begin
            logic g;
            bus.wr_req_vld = ($urandom_range(0, 3) != 0);
            bus.wr_cmplt   = (wcnt > 0) && ($urandom_range(0, 2) == 0);
            g = (wcnt < 8);
            push($sformatf("rw%0d.gnt", i), S_WGNT, 32'(g));
            drain();
            if (bus.wr_req_vld && g && !bus.wr_cmplt)      wcnt++;
            else if (!(bus.wr_req_vld && g) && bus.wr_cmplt) wcnt--;
            push($sformatf("rw%0d.wcnt", i), S_WCNT, 32'(wcnt));
            step();
        end
        bus.wr_req_vld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_cmplt = (wcnt > 0);
            if (wcnt > 0) wcnt--;
            step();
        end
        bus.wr_cmplt = 1'b0;
        push("rw.empty", S_WCNT, 32'd0);
        drain();

        // reset mid-operation, then a stray completion
        bus.rd_req_vld = 1'b1;
        step();
        step();
        bus.rd_req_vld = 1'b0; req = 1'b1;
        step();
        rst = 1'b1; req = 1'b0;
        push_ctl("mrst", RUN, 1'b0, 1'b1);
        push("mrst.rcnt", S_RCNT, 32'd0);
        push("mrst.err", S_ERR, 32'd0);
        step();
        rst = 1'b0;
        bus.rd_cmplt = 1'b1;
        push("mrst.stray.err", S_ERR, 32'd1);
        push("mrst.stray.rcnt", S_RCNT, 32'd0);
        step();
        bus.rd_cmplt = 1'b0;

`ifdef BIU_LPMD_RESIDENCY_CNT_EN
        for (int rep = 0; rep < 2; rep++) begin
            req = 1'b1;
            step();
            push($sformatf("res%0d.noop", rep), S_STATE, 32'(NOP));
            step();
            req = 1'b0; lpmd = 2'b00;
            push($sformatf("res%0d.lpmd", rep), S_STATE, 32'(LPM));
            push($sformatf("res%0d.ent", rep), S_ENT, 32'(rep + 1));
            step();
            for (int i = 0; i < 99; i++) step();
            lpmd = 2'b11;
            push($sformatf("res%0d.run", rep), S_STATE, 32'(RUN));
            push($sformatf("res%0d.cyc", rep), S_CYC, 32'(100 * (rep + 1)));
            step();
        end
        push("res.cyc200", S_CYC, 32'd200);
        push("res.ent2", S_ENT, 32'd2);
        drain();
        req = 1'b1;
        step();
        step();
        req = 1'b0; lpmd = 2'b00;
        step();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; lpmd = 2'b11;
        push("res.rst.state", S_STATE, 32'(RUN));
        push("res.rst.cyc", S_CYC, 32'd0);
        push("res.rst.ent", S_ENT, 32'd0);
        step();
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
